// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: FSM encoding,
// scoreboard slot layout and forward-select bit positions.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ctrlState_t;

    // Per-slot status flags; the destination address is held alongside so
    // that REG_AW stays a module parameter.
    typedef struct packed {
        logic valid;
        logic regWr;
        logic isLoad;
    } slotFlags_t;

    localparam slotFlags_t SLOT_EMPTY = '0;

    localparam int unsigned NUM_SLOTS = 3;
    localparam int unsigned SLOT_EX   = 0;
    localparam int unsigned SLOT_MEM  = 1;

    // exFwd bit positions, lined up with exCtrl[6:3]
    localparam int unsigned FWD_EXMEM_A = 0;
    localparam int unsigned FWD_EXMEM_B = 1;
    localparam int unsigned FWD_MEMWB_A = 2;
    localparam int unsigned FWD_MEMWB_B = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// Three-slot scoreboard of in-flight destinations (EX, MEM, WB) plus the
// source-register match comparators for the EX and MEM slots.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pushRegWr,
    input  logic              pushIsLoad,
    input  logic [REG_AW-1:0] pushRW,
    input  logic [REG_AW-1:0] rS1,
    input  logic [REG_AW-1:0] rS2,
    output logic              exMatchS1,
    output logic              exMatchS2,
    output logic              memMatchS1,
    output logic              memMatchS2,
    output logic              exIsLoad,
    output logic              memIsLoad
);

    slotFlags_t        flags [NUM_SLOTS];
    logic [REG_AW-1:0] dst   [NUM_SLOTS];

    // A slot hazards only if it writes a nonzero register equal to r
    function automatic logic slotHit(input slotFlags_t f,
                                     input logic [REG_AW-1:0] d,
                                     input logic [REG_AW-1:0] r);
        return f.valid && f.regWr && (d == r) && (r != '0);
    endfunction

    // Advance the pipeline image; EX takes the ID instruction or a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                flags[i] <= SLOT_EMPTY;
                dst[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_SLOTS; i++) begin
                flags[i] <= flags[i-1];
                dst[i]   <= dst[i-1];
            end
            flags[SLOT_EX] <= push ? slotFlags_t'{valid: 1'b1, regWr: pushRegWr, isLoad: pushIsLoad}
                                   : SLOT_EMPTY;
            dst[SLOT_EX]   <= pushRW;
        end
    end

    // Match comparators against the current ID source registers
    always_comb begin
        exMatchS1  = slotHit(flags[SLOT_EX],  dst[SLOT_EX],  rS1);
        exMatchS2  = slotHit(flags[SLOT_EX],  dst[SLOT_EX],  rS2);
        memMatchS1 = slotHit(flags[SLOT_MEM], dst[SLOT_MEM], rS1);
        memMatchS2 = slotHit(flags[SLOT_MEM], dst[SLOT_MEM], rS2);
        exIsLoad   = flags[SLOT_EX].isLoad;
        memIsLoad  = flags[SLOT_MEM].isLoad;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller: load-use and branch stalls, forward
// selects, pipeline holds and the halt/drain/end-of-program sequence.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rS1,
    input  logic [REG_AW-1:0] rS2,
    input  logic [REG_AW-1:0] rW,
    input  logic              usesS1,
    input  logic              usesS2,
    input  logic              memWrId,
    input  logic              regWrId,
    input  logic              memRdId,
    input  logic              branchId,
    input  logic              haltId,
    output logic              stall,
    output logic              ifIdWrIn,
    output logic              pcWr,
    output logic              bubble,
    output logic [1:0]        idFwd,
    output logic [3:0]        exFwd,
    output logic              memWbMem,
    output logic              endProgram,
    output logic [CNT_W-1:0]  stallCount
);

    localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);

    ctrlState_t        state;
    logic [DCNT_W-1:0] drainCnt;

    logic exMatchS1, exMatchS2, memMatchS1, memMatchS2;
    logic exIsLoad, memIsLoad;
    logic loadUse, branchHaz;

    hazard_scoreboard #(
        .REG_AW(REG_AW)
    ) uScoreboard (
        .clk        (clk),
        .reset      (reset),
        .push       (!bubble),
        .pushRegWr  (regWrId),
        .pushIsLoad (memRdId),
        .pushRW     (rW),
        .rS1        (rS1),
        .rS2        (rS2),
        .exMatchS1  (exMatchS1),
        .exMatchS2  (exMatchS2),
        .memMatchS1 (memMatchS1),
        .memMatchS2 (memMatchS2),
        .exIsLoad   (exIsLoad),
        .memIsLoad  (memIsLoad)
    );

    // Stall sources: load-use in EX, or a branch needing a value not yet in ID
    always_comb begin
        loadUse   = exIsLoad & ((exMatchS1 & usesS1) | (exMatchS2 & usesS2 & ~memWrId));
        branchHaz = branchId & (exMatchS1 | (memMatchS1 & memIsLoad));
    end

    // Holds, bubble and forward selects; everything is quiet while reset is high
    always_comb begin
        stall    = 1'b0;
        ifIdWrIn = 1'b0;
        pcWr     = 1'b0;
        bubble   = 1'b1;
        idFwd    = '0;
        exFwd    = '0;
        memWbMem = 1'b0;
        if (!reset) begin
            if (state == RUN) begin
                stall    = loadUse | branchHaz;
                ifIdWrIn = ~stall;
                pcWr     = ~stall;
                bubble   = stall;
            end
            if (!stall) begin
                idFwd[0] = memMatchS1 & ~memIsLoad;
                idFwd[1] = memMatchS2 & ~memIsLoad;
                exFwd[FWD_EXMEM_A] = exMatchS1 & ~exIsLoad & ~branchId;
                exFwd[FWD_EXMEM_B] = exMatchS2 & ~exIsLoad & ~branchId;
                exFwd[FWD_MEMWB_A] = memMatchS1 & memIsLoad & ~exFwd[FWD_EXMEM_A];
                exFwd[FWD_MEMWB_B] = memMatchS2 & memIsLoad & ~exFwd[FWD_EXMEM_B];
                memWbMem = memWrId & exMatchS2 & exIsLoad;
            end
        end
    end

    // Program-end sequencer: accept halt, drain EX/MEM/WB, then latch endProgram
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            drainCnt   <= '0;
            endProgram <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (haltId && !stall) begin
                        state    <= DRAIN;
                        drainCnt <= DCNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0) begin
                        state      <= DONE;
                        endProgram <= 1'b1;
                    end else begin
                        drainCnt <= drainCnt - 1'b1;
                    end
                end
                DONE: begin
                    endProgram <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Count stalled cycles, wrapping naturally at the counter width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stall) begin
            stallCount <= stallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios,
// randomized traffic against an in-flight instruction model, and halt/drain.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 32;
    localparam int unsigned DC = 3;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rS1, rS2, rW;
    logic          usesS1, usesS2, memWrId, regWrId, memRdId, branchId, haltId;
    logic          stall, ifIdWrIn, pcWr, bubble, memWbMem, endProgram;
    logic [1:0]    idFwd;
    logic [3:0]    exFwd;
    logic [CW-1:0] stallCount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES(DC),
        .REG_AW      (AW),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rS1        (rS1),
        .rS2        (rS2),
        .rW         (rW),
        .usesS1     (usesS1),
        .usesS2     (usesS2),
        .memWrId    (memWrId),
        .regWrId    (regWrId),
        .memRdId    (memRdId),
        .branchId   (branchId),
        .haltId     (haltId),
        .stall      (stall),
        .ifIdWrIn   (ifIdWrIn),
        .pcWr       (pcWr),
        .bubble     (bubble),
        .idFwd      (idFwd),
        .exFwd      (exFwd),
        .memWbMem   (memWbMem),
        .endProgram (endProgram),
        .stallCount (stallCount)
    );

    // ---------------- reference model: list of in-flight instructions ----------------
    // index 0 = youngest (in EX), 1 = MEM, 2 = WB
    bit            mValid [3];
    bit            mWr    [3];
    bit            mLd    [3];
    logic [AW-1:0] mDst   [3];
    int            mPhase;      // 0 running, 1 draining, 2 finished
    int            mLeft;       // drain cycles still to go
    logic [CW-1:0] mStalls;

    bit         eStall, eIfId, ePc, eBubble, eMemWbMem;
    logic [1:0] eIdFwd;
    logic [3:0] eExFwd;

    function automatic bit hits(input int s, input logic [AW-1:0] r);
        return mValid[s] && mWr[s] && (mDst[s] == r) && (r != 0);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mValid[i] = 0; mWr[i] = 0; mLd[i] = 0; mDst[i] = '0;
        end
        mPhase  = 0;
        mLeft   = 0;
        mStalls = '0;
    endtask

    task automatic calcExp();
        bit ldUse, br, aEx, bEx;
        ldUse = mLd[0] && ((hits(0, rS1) && usesS1) || (hits(0, rS2) && usesS2 && !memWrId));
        br    = branchId && (hits(0, rS1) || (hits(1, rS1) && mLd[1]));
        eStall = 0; eIfId = 0; ePc = 0; eBubble = 1;
        eIdFwd = '0; eExFwd = '0; eMemWbMem = 0;
        if (!reset) begin
            if (mPhase == 0) begin
                eStall  = ldUse || br;
                eIfId   = !eStall;
                ePc     = !eStall;
                eBubble = eStall;
            end
            if (!eStall) begin
                aEx = hits(0, rS1) && !mLd[0] && !branchId;
                bEx = hits(0, rS2) && !mLd[0] && !branchId;
                eIdFwd = {hits(1, rS2) && !mLd[1], hits(1, rS1) && !mLd[1]};
                eExFwd = {hits(1, rS2) && mLd[1] && !bEx, hits(1, rS1) && mLd[1] && !aEx, bEx, aEx};
                eMemWbMem = memWrId && hits(0, rS2) && mLd[0];
            end
        end
    endtask

    task automatic modelClock();
        if (reset) begin
            modelReset();
        end else begin
            if (eStall) mStalls = mStalls + 1;
            if (mPhase == 0 && haltId && !eStall) begin
                mPhase = 1;
                mLeft  = DC;
            end else if (mPhase == 1) begin
                mLeft = mLeft - 1;
                if (mLeft == 0) mPhase = 2;
            end
            for (int i = 2; i > 0; i--) begin
                mValid[i] = mValid[i-1]; mWr[i] = mWr[i-1];
                mLd[i]    = mLd[i-1];    mDst[i] = mDst[i-1];
            end
            mValid[0] = !eBubble;
            mWr[0]    = !eBubble && regWrId;
            mLd[0]    = !eBubble && memRdId;
            mDst[0]   = rW;
        end
    endtask

    // one clock: expectations from pre-edge inputs, then model update; returns at negedge
    task automatic advance();
        calcExp();
        @(posedge clk);
        modelClock();
        @(negedge clk);
    endtask

    task automatic setId(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] w,
                         input bit u1, input bit u2, input bit sw, input bit wr,
                         input bit ld, input bit br, input bit ht);
        rS1 = a; rS2 = b; rW = w;
        usesS1 = u1; usesS2 = u2; memWrId = sw; regWrId = wr;
        memRdId = ld; branchId = br; haltId = ht;
    endtask

    task automatic nop();
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        nop();
        repeat (3) advance();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nop();
        modelReset();
        #2 reset = 1'b1;
        @(negedge clk);
        setId(3, 3, 3, 1, 1, 0, 1, 1, 1, 1);
        #1;
        checks++;
        if ({stall, ifIdWrIn, pcWr, bubble, idFwd, exFwd, memWbMem, endProgram} !== 12'b0001_00_0000_00) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {stall, ifIdWrIn, pcWr, bubble, idFwd, exFwd, memWbMem, endProgram}, 12'b000100000000);
        end
        checks++;
        if (stallCount !== '0) begin
            failures++;
            $display("FAIL reset_stallCount: got %0d expected 0", stallCount);
        end
        @(negedge clk);
        reset = 1'b0;
        nop();
        #1;
        checks++;
        if ({pcWr, ifIdWrIn, bubble} !== 3'b110) begin
            failures++;
            $display("FAIL reset_release: got %b expected 110", {pcWr, ifIdWrIn, bubble});
        end
    endtask

    task automatic test_alu_forward();
        setId(1, 2, 3, 1, 1, 0, 1, 0, 0, 0);   // add r3,r1,r2
        advance();
        setId(3, 4, 5, 1, 1, 0, 1, 0, 0, 0);   // sub r5,r3,r4
        #1;
        checks++;
        if ({stall, bubble, exFwd} !== 6'b00_0001) begin
            failures++;
            $display("FAIL alu_forward: got %b expected 000001", {stall, bubble, exFwd});
        end
        advance();
        flush();
    endtask

    task automatic test_load_use();
        logic [CW-1:0] base;
        base = mStalls;
        setId(1, 0, 3, 1, 0, 0, 1, 1, 0, 0);   // lw r3
        advance();
        setId(3, 4, 5, 1, 1, 0, 1, 0, 0, 0);   // add r5,r3,r4
        #1;
        checks++;
        if ({stall, ifIdWrIn, pcWr, bubble} !== 4'b1001) begin
            failures++;
            $display("FAIL load_use_stall: got %b expected 1001", {stall, ifIdWrIn, pcWr, bubble});
        end
        advance();
        #1;
        checks++;
        if ({stall, ifIdWrIn, exFwd} !== 6'b01_0100) begin
            failures++;
            $display("FAIL load_use_resume: got %b expected 010100", {stall, ifIdWrIn, exFwd});
        end
        checks++;
        if (stallCount !== base + 1) begin
            failures++;
            $display("FAIL load_use_count: got %0d expected %0d", stallCount, base + 1);
        end
        advance();
        flush();
    endtask

    task automatic test_store_data();
        setId(1, 0, 3, 1, 0, 0, 1, 1, 0, 0);   // lw r3
        advance();
        setId(1, 3, 0, 1, 0, 1, 0, 0, 0, 0);   // sw r3 -> 0(r1)
        #1;
        checks++;
        if ({stall, pcWr, memWbMem, exFwd} !== 7'b011_0000) begin
            failures++;
            $display("FAIL store_data_fwd: got %b expected 0110000", {stall, pcWr, memWbMem, exFwd});
        end
        advance();
        flush();
    endtask

    task automatic test_branch_load();
        logic [CW-1:0] base;
        base = mStalls;
        setId(1, 0, 3, 1, 0, 0, 1, 1, 0, 0);   // lw r3
        advance();
        setId(3, 0, 0, 1, 0, 0, 0, 0, 1, 0);   // beq r3,r0
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL branch_stall_1: got %b expected 1", stall);
        end
        advance();
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL branch_stall_2: got %b expected 1", stall);
        end
        advance();
        #1;
        checks++;
        if ({stall, pcWr, idFwd} !== 4'b0100) begin
            failures++;
            $display("FAIL branch_resume: got %b expected 0100", {stall, pcWr, idFwd});
        end
        checks++;
        if (stallCount !== base + 2) begin
            failures++;
            $display("FAIL branch_count: got %0d expected %0d", stallCount, base + 2);
        end
        advance();
        flush();
    endtask

    task automatic test_r0();
        setId(1, 2, 0, 1, 1, 0, 1, 0, 0, 0);   // add r0,r1,r2
        advance();
        setId(0, 0, 6, 1, 1, 0, 1, 0, 0, 0);   // add r6,r0,r0
        #1;
        checks++;
        if ({stall, idFwd, exFwd, memWbMem} !== 8'b0) begin
            failures++;
            $display("FAIL r0_alu: got %b expected 00000000", {stall, idFwd, exFwd, memWbMem});
        end
        advance();
        flush();
        setId(1, 0, 0, 1, 0, 0, 1, 1, 0, 0);   // lw r0
        advance();
        setId(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);   // branch/store on r0
        #1;
        checks++;
        if ({stall, idFwd, exFwd, memWbMem} !== 8'b0) begin
            failures++;
            $display("FAIL r0_load: got %b expected 00000000", {stall, idFwd, exFwd, memWbMem});
        end
        advance();
        flush();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            setId(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'b0);
            #1;
            calcExp();
            checks++;
            if ({stall, ifIdWrIn, pcWr, bubble, idFwd, exFwd, memWbMem, endProgram} !==
                {eStall, eIfId, ePc, eBubble, eIdFwd, eExFwd, eMemWbMem, 1'b0}) begin
                failures++;
                $display("FAIL random_outputs[%0d]: got %b expected %b", n,
                         {stall, ifIdWrIn, pcWr, bubble, idFwd, exFwd, memWbMem, endProgram},
                         {eStall, eIfId, ePc, eBubble, eIdFwd, eExFwd, eMemWbMem, 1'b0});
            end
            checks++;
            if (stallCount !== mStalls) begin
                failures++;
                $display("FAIL random_stallCount[%0d]: got %0d expected %0d", n, stallCount, mStalls);
            end
            advance();
        end
        flush();
    endtask

    task automatic test_halt_drain();
        setId(1, 0, 3, 1, 0, 0, 1, 1, 0, 0);   // lw r3
        advance();
        setId(3, 0, 0, 1, 0, 0, 0, 0, 0, 1);   // halt that reads r3: stalled first
        #1;
        checks++;
        if ({stall, pcWr} !== 2'b10) begin
            failures++;
            $display("FAIL halt_while_stalled: got %b expected 10", {stall, pcWr});
        end
        advance();
        #1;
        checks++;
        if ({stall, pcWr, endProgram} !== 3'b010) begin
            failures++;
            $display("FAIL halt_accept: got %b expected 010", {stall, pcWr, endProgram});
        end
        advance();
        nop();
        for (int i = 0; i < int'(DC); i++) begin
            #1;
            checks++;
            if ({stall, ifIdWrIn, pcWr, bubble, endProgram} !== 5'b00010) begin
                failures++;
                $display("FAIL drain_cycle[%0d]: got %b expected 00010", i,
                         {stall, ifIdWrIn, pcWr, bubble, endProgram});
            end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({stall, ifIdWrIn, pcWr, bubble, endProgram} !== 5'b00011) begin
                failures++;
                $display("FAIL done_cycle[%0d]: got %b expected 00011", i,
                         {stall, ifIdWrIn, pcWr, bubble, endProgram});
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_drain();
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // halt
        advance();
        nop();
        #1;
        checks++;
        if ({pcWr, bubble, endProgram} !== 3'b010) begin
            failures++;
            $display("FAIL mid_drain_entry: got %b expected 010", {pcWr, bubble, endProgram});
        end
        advance();
        reset = 1'b1;
        modelReset();
        #1;
        checks++;
        if ({stall, ifIdWrIn, pcWr, bubble, endProgram} !== 5'b00010 || stallCount !== '0) begin
            failures++;
            $display("FAIL mid_drain_reset: got %b cnt %0d expected 00010 cnt 0",
                     {stall, ifIdWrIn, pcWr, bubble, endProgram}, stallCount);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({pcWr, bubble, endProgram} !== 3'b100) begin
                failures++;
                $display("FAIL after_reset_run[%0d]: got %b expected 100", i, {pcWr, bubble, endProgram});
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_store_data();
        test_branch_load();
        test_r0();
        test_random();
        test_halt_drain();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipeline datapath. It keeps a 3-slot scoreboard of in-flight destination registers for the EX, MEM and WB stages. Each cycle it compares the decoded ID-stage instruction against that scoreboard and drives:
- the forwarding selects, into idCtrl[2:1], exCtrl[6:3] and memCtrl[4];
- the IF/ID hold, the PC hold and the ID/EX bubble.
It also sequences program end: it drains the pipeline, then raises endProgram.

Parameters:
DRAIN_CYCLES, 3, cycles after halt accepted before endProgram (EX, MEM, WB)
REG_AW, 5, register address width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock; scoreboard updates on rising edge
reset  in  1  asynchronous, active-high
rS1  in  REG_AW  ID source register A
rS2  in  REG_AW  ID source register B
rW  in  REG_AW  ID final destination (after regDst/link mux)
usesS1  in  1  ID instruction reads rS1 (ALU/EX or branch)
usesS2  in  1  ID instruction reads rS2 as ALU operand
memWrId  in  1  ID instruction is a store (rS2 is store data)
regWrId  in  1  ID instruction writes rW
memRdId  in  1  ID instruction is a load
branchId  in  1  ID instruction resolves on busA in ID
haltId  in  1  ID instruction is program-end
stall  out  1  hazard stall this cycle
ifIdWrIn  out  1  IF/ID write enable (0 = hold)
pcWr  out  1  PC write enable
bubble  out  1  zero ID/EX control this cycle
idFwd  out  2  {exMemIdB, exMemIdA}
exFwd  out  4  {memWbExB, memWbExA, exMemExB, exMemExA}
memWbMem  out  1  store-data forward from WB
endProgram  out  1  pipeline drained after halt
stallCount  out  CNT_W  cycles with stall=1 since reset

Behaviour:
- Scoreboard slots: EX, MEM, WB. Each slot is {valid, regWr, isLoad, rW}.
- Per clock: WB<=MEM, MEM<=EX. EX<=ID info, or EX<=invalid when bubble=1.
- "match(s,r)" means: slot s valid, s.regWr, s.rW==r, and r!=0. Register 0 never hazards or forwards.
- WB-slot matches need no action: the register file writes on the falling edge.
- Load-use stall conditions:
  - match(EX,rS1) & EX.isLoad & usesS1;
  - match(EX,rS2) & EX.isLoad & usesS2 & !memWrId.
  - Exception: a store whose only match is its data operand does not stall. Instead it sets memWbMem=1.
- Branch stall conditions (branchId):
  - match(EX,rS1), any EX type;
  - match(MEM,rS1) & MEM.isLoad.
  - An EX load therefore stalls a branch 2 cycles.
  - Stalls recompute every cycle from the scoreboard; there is no stall counter state.
- Forwarding, evaluated only when stall=0; all selects are 0 while stalled:
  - exMemIdA = match(MEM,rS1) & !MEM.isLoad. exMemIdB is the same with rS2.
  - exMemExA = match(EX,rS1) & !EX.isLoad & !branchId. exMemExB is the same with rS2.
  - memWbExA = match(MEM,rS1) & MEM.isLoad & !exMemExA. memWbExB is the same with rS2.
  - memWbMem = memWrId & match(EX,rS2) & EX.isLoad.
  - Priority: the EX match (youngest) wins over the MEM match.
- When stall=1: ifIdWrIn=0, pcWr=0, bubble=1, and stallCount increments (wraps at 2^CNT_W).
- FSM states: RUN, DRAIN, DONE.
  - RUN: ifIdWrIn=pcWr=!stall, bubble=stall.
  - RUN->DRAIN when haltId & !stall. The halt instruction itself enters EX normally. The drain counter loads DRAIN_CYCLES-1.
  - DRAIN: ifIdWrIn=0, pcWr=0, bubble=1, stall=0. The counter decrements; at 0 the FSM goes to DONE.
  - DONE: same holds as DRAIN, plus endProgram=1. The FSM stays in DONE until reset.
  - haltId while stalled is ignored until the stall clears.
- Reset, asynchronous, at any point including mid-DRAIN:
  - scoreboard all invalid, state RUN, counter 0, stallCount 0;
  - outputs while reset=1: stall=0, ifIdWrIn=0, pcWr=0, bubble=1, all forward selects 0, endProgram=0.
- All outputs except stallCount and endProgram are combinational from state, scoreboard and ID inputs. No same-cycle loops through stall.

Decomposition:
- Shared package:
  - FSM state encoding (RUN=2'd0, DRAIN=2'd1, DONE=2'd2);
  - scoreboard slot struct/field widths;
  - the exFwd bit positions matching exCtrl[6:3].
- One natural sub-module, hazard_scoreboard: the 3-slot shift register plus match comparators. The top level holds the stall/forward logic, the FSM and the counter.

Test Plan:
- EX slot "add r3" (ALU), ID "sub r5,r3,r4" -> exFwd=4'b0001, stall=0, bubble=0.
- EX slot "lw r3", ID "add r5,r3,r4" -> stall=1 for 1 cycle, stallCount=1; next cycle exFwd=4'b0100, ifIdWrIn=1.
- EX slot "lw r3", ID "sw r3 data" (rS2=3, memWrId=1, usesS2=0) -> stall=0, memWbMem=1.
- EX slot "lw r3", ID "beq on r3" -> stall=1 for exactly 2 cycles; third cycle stall=0, idFwd=0.
- EX slot writes r0 (regWr=1), ID reads r0 -> stall=0, all forward selects 0.
- haltId=1 with stall=0 -> DRAIN for 3 cycles with bubble=1 and pcWr=0, then endProgram=1 held. Assert reset during DRAIN -> endProgram=0 and state RUN immediately.
